// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: two-requester round-robin front end feeding one shared
// binary-to-Gray converter. A grant latches the winner's operand; the result
// appears one clock later with a one-cycle dvalid pulse and the owner's id.
module gray_conv_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             did,
    output logic             busy,
    output logic [7:0]       cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Binary to reflected Gray code.
    function automatic logic [WIDTH-1:0] gray_f(input logic [WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] op_r;
    logic             id_r;
    logic             last_r;
    logic             gnt0_r;
    logic             gnt1_r;
    logic [WIDTH-1:0] dout_r;
    logic             dvalid_r;
    logic             did_r;
    logic [7:0]       cnt_r;

    logic             win_any_s;
    logic             win_id_s;
    logic [WIDTH-1:0] win_din_s;

    // Arbitration: lone requester wins; on a tie the one not served last wins.
    always_comb begin
        win_any_s = req0 | req1;
        win_id_s  = 1'b0;
        if (req0 && req1) begin
            win_id_s = ~last_r;
        end else if (req1) begin
            win_id_s = 1'b1;
        end else begin
            win_id_s = 1'b0;
        end
        if (win_id_s) begin
            win_din_s = din1;
        end else begin
            win_din_s = din0;
        end
    end

    // Control FSM with registered grants, result, id and saturating count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            op_r     <= {WIDTH{1'b0}};
            id_r     <= 1'b0;
            last_r   <= 1'b1;
            gnt0_r   <= 1'b0;
            gnt1_r   <= 1'b0;
            dout_r   <= {WIDTH{1'b0}};
            dvalid_r <= 1'b0;
            did_r    <= 1'b0;
            cnt_r    <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    dvalid_r <= 1'b0;
                    if (win_any_s) begin
                        op_r    <= win_din_s;
                        id_r    <= win_id_s;
                        last_r  <= win_id_s;
                        gnt0_r  <= ~win_id_s;
                        gnt1_r  <= win_id_s;
                        state_r <= CONV;
                    end else begin
                        gnt0_r  <= 1'b0;
                        gnt1_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                CONV: begin
                    // Requests are ignored here; a held req re-arbitrates in IDLE.
                    gnt0_r   <= 1'b0;
                    gnt1_r   <= 1'b0;
                    dout_r   <= gray_f(op_r);
                    did_r    <= id_r;
                    dvalid_r <= 1'b1;
                    if (cnt_r != 8'hFF) begin
                        cnt_r <= cnt_r + 8'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    gnt0_r   <= 1'b0;
                    gnt1_r   <= 1'b0;
                    dvalid_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign gnt0   = gnt0_r;
    assign gnt1   = gnt1_r;
    assign dout   = dout_r;
    assign dvalid = dvalid_r;
    assign did    = did_r;
    assign cnt    = cnt_r;
    assign busy   = (state_r == CONV);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: a cycle reference model pushes
// expected results to a scoreboard at each grant and pops them on dvalid,
// plus directed checks for the listed scenarios.
module tb_gray_conv_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic [3:0] din0;
    logic       req1;
    logic [3:0] din1;
    logic       gnt0;
    logic       gnt1;
    logic [3:0] dout;
    logic       dvalid;
    logic       did;
    logic       busy;
    logic [7:0] cnt;

    gray_conv_arbiter #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .din0   (din0),
        .req1   (req1),
        .din1   (din1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .dout   (dout),
        .dvalid (dvalid),
        .did    (did),
        .busy   (busy),
        .cnt    (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected Gray codes written out as a table, independent of any XOR.
    logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    // Scoreboard entries: {id, operand}
    logic [4:0] sb [$];

    // Reference model state
    logic       m_conv;
    logic       m_last;
    logic       m_id;
    logic [3:0] m_op;
    logic       m_gnt0;
    logic       m_gnt1;
    logic       m_dvalid;
    logic [3:0] m_dout;
    logic       m_did;
    logic [7:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock: sample inputs at the rising edge, then update the
    // model and compare against the DUT at the falling edge.
    task automatic step();
        logic       s_rst;
        logic       s_r0;
        logic       s_r1;
        logic [3:0] s_d0;
        logic [3:0] s_d1;
        logic       w;
        logic [4:0] e;
        @(posedge clk);
        s_rst = rst_n;
        s_r0  = req0;
        s_r1  = req1;
        s_d0  = din0;
        s_d1  = din1;
        @(negedge clk);
        if (!s_rst) begin
            m_conv = 1'b0; m_last = 1'b1; m_id = 1'b0; m_op = 4'd0;
            m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_dvalid = 1'b0;
            m_dout = 4'd0; m_did = 1'b0; m_cnt = 8'd0;
            sb.delete();
        end else if (!m_conv) begin
            m_dvalid = 1'b0;
            if (s_r0 || s_r1) begin
                w      = (s_r0 && s_r1) ? ~m_last : s_r1;
                m_last = w;
                m_id   = w;
                m_op   = w ? s_d1 : s_d0;
                m_gnt0 = ~w;
                m_gnt1 = w;
                m_conv = 1'b1;
                sb.push_back({w, m_op});
            end else begin
                m_gnt0 = 1'b0;
                m_gnt1 = 1'b0;
            end
        end else begin
            m_gnt0   = 1'b0;
            m_gnt1   = 1'b0;
            m_dvalid = 1'b1;
            m_dout   = gray_tab[m_op];
            m_did    = m_id;
            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            m_conv   = 1'b0;
        end
        check_eq("gnt0", gnt0, m_gnt0);
        check_eq("gnt1", gnt1, m_gnt1);
        check_eq("gnt_excl", gnt0 & gnt1, 0);
        check_eq("dvalid", dvalid, m_dvalid);
        check_eq("busy", busy, m_conv);
        check_eq("cnt", cnt, m_cnt);
        check_eq("dout_hold", dout, m_dout);
        check_eq("did_hold", did, m_did);
        if (dvalid === 1'b1) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("sb_dout", dout, gray_tab[e[3:0]]);
                check_eq("sb_did", did, e[4]);
            end else begin
                check_eq("sb_underflow", sb.size(), 1);
            end
        end
    endtask

    initial begin
        int res_dout [8];
        int res_did  [8];
        int res_cyc  [8];
        int n_res;
        int n_dv;

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; din0 = 4'd0; din1 = 4'd0;
        step();
        step();
        check_eq("rst_dout", dout, 0);
        check_eq("rst_cnt", cnt, 0);
        check_eq("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Single requester
        req0 = 1'b1; din0 = 4'd10;
        step();
        check_eq("s1_gnt0", gnt0, 1);
        req0 = 1'b0;
        step();
        check_eq("s1_dvalid", dvalid, 1);
        check_eq("s1_dout", dout, 15);
        check_eq("s1_did", did, 0);
        check_eq("s1_cnt", cnt, 1);
        step();
        check_eq("s1_pulse", dvalid, 0);
        step();

        // Simultaneous held requests alternate
        req0 = 1'b1; req1 = 1'b1; din0 = 4'd13; din1 = 4'd14;
        n_res = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (dvalid === 1'b1 && n_res < 8) begin
                res_dout[n_res] = int'(dout);
                res_did[n_res]  = int'(did);
                res_cyc[n_res]  = i;
                n_res++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check_eq("s2_count", n_res, 4);
        for (int k = 0; k < n_res; k++) begin
            check_eq("s2_dout", res_dout[k], (res_did[k] == 1) ? 9 : 11);
            if (k > 0) begin
                check_eq("s2_alt", res_did[k], 1 - res_did[k-1]);
                check_eq("s2_gap", res_cyc[k] - res_cyc[k-1], 2);
            end
        end
        step();
        step();

        // Sweep of all operands through requester 1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int v = 0; v < 16; v++) begin
            req1 = 1'b1; din1 = 4'(v);
            step();
            check_eq("s3_gnt1", gnt1, 1);
            req1 = 1'b0; din1 = ~4'(v);
            step();
            check_eq("s3_dvalid", dvalid, 1);
            check_eq("s3_dout", dout, gray_tab[v]);
        end
        check_eq("s3_cnt", cnt, 16);
        step();

        // Request arriving during CONV waits for the next IDLE edge
        req0 = 1'b1; din0 = 4'd6;
        step();
        check_eq("s4_gnt0", gnt0, 1);
        req0 = 1'b0; req1 = 1'b1; din1 = 4'd9;
        step();
        check_eq("s4_no_gnt1", gnt1, 0);
        check_eq("s4_dv0", dvalid, 1);
        check_eq("s4_dout0", dout, 5);
        step();
        check_eq("s4_gnt1", gnt1, 1);
        req1 = 1'b0;
        step();
        check_eq("s4_dv1", dvalid, 1);
        check_eq("s4_did1", did, 1);
        check_eq("s4_dout1", dout, 13);
        step();

        // Reset during CONV abandons the conversion
        req0 = 1'b1; din0 = 4'd5;
        step();
        check_eq("s5_busy", busy, 1);
        req0 = 1'b0; rst_n = 1'b0;
        step();
        check_eq("s5_dvalid", dvalid, 0);
        check_eq("s5_dout", dout, 0);
        check_eq("s5_cnt", cnt, 0);
        check_eq("s5_busy0", busy, 0);
        rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1; din0 = 4'd3; din1 = 4'd7;
        step();
        check_eq("s5_tie_gnt0", gnt0, 1);
        check_eq("s5_tie_gnt1", gnt1, 0);
        req0 = 1'b0; req1 = 1'b0;
        step();
        check_eq("s5_dout", dout, 2);
        check_eq("s5_did", did, 0);
        step();

        // Saturation over 260 back-to-back conversions
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_dv = 0;
        req0 = 1'b1;
        for (int i = 0; i < 520; i++) begin
            din0 = 4'($urandom_range(0, 15));
            step();
            if (dvalid === 1'b1) n_dv++;
        end
        req0 = 1'b0;
        step();
        check_eq("s6_dv_count", n_dv, 260);
        check_eq("s6_cnt_sat", cnt, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; the only supported value is 4.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low, sampled on the rising edge of clk.
REQ-004 req0  input  1  requester 0 level request; din0 is valid while req0 is high.
REQ-005 din0  input  WIDTH  requester 0 binary operand.
REQ-006 req1  input  1  requester 1 level request; din1 is valid while req1 is high.
REQ-007 din1  input  WIDTH  requester 1 binary operand.
REQ-008 gnt0  output  1  registered, one-cycle pulse: requester 0 operand accepted.
REQ-009 gnt1  output  1  registered, one-cycle pulse: requester 1 operand accepted.
REQ-010 dout  output  WIDTH  registered Gray-code result.
REQ-011 dvalid  output  1  registered, one-cycle pulse: dout holds a new result.
REQ-012 did  output  1  registered requester id (0 or 1) that owns the current dout.
REQ-013 busy  output  1  high while the FSM is in CONV.
REQ-014 cnt  output  8  saturating count of completed conversions.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and CONV. Reset state is IDLE.
REQ-016 The block SHALL contain one shared converter. It SHALL compute gray = op XOR (op >> 1) on the latched operand op. For WIDTH=4: 0->0, 1->1, 2->3, 3->2, 4->6, 5->7, 6->5, 7->4, 8->12, 9->13, 10->15, 11->14, 12->10, 13->11, 14->9, 15->8.
REQ-017 IDLE, neither req high:
  - remain IDLE;
  - gnt0 = gnt1 = 0.
REQ-018 IDLE, at least one req high, at edge E:
  - latch the winner's din into op;
  - latch the winner's id;
  - assert that winner's gnt for the cycle after E;
  - go to CONV.
REQ-019 Arbitration:
  - a single requester wins when it is the only one asserting req;
  - on a simultaneous req0 and req1, the winner is the requester not served last (round-robin);
  - the last-served pointer updates only on a grant.
REQ-020 CONV, at the next edge E+1:
  - dout <= gray(op);
  - did <= latched id;
  - dvalid = 1 for the following cycle only;
  - cnt increments by 1;
  - go to IDLE.
  Request-to-result latency is 2 clocks; maximum throughput is one conversion per 2 clocks.
REQ-021 In CONV, req0 and req1 SHALL be ignored. No grant is issued and no request is queued.
REQ-022 A req still high in the IDLE cycle after a conversion SHALL be treated as a new request. Requesters SHALL drop req in the cycle gnt is seen if they want only one conversion.
REQ-023 din0 and din1 SHALL be sampled only at the granting edge. Later changes SHALL NOT affect the result in flight.
REQ-024 dout and did SHALL hold their last value until the next conversion completes.
REQ-025 cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-026 gnt0 and gnt1 SHALL never be high in the same cycle. At most one dvalid pulse SHALL occur per grant.
REQ-027 busy SHALL equal (state == CONV).

Reset
REQ-028 When rst_n is low at an edge, the block SHALL set:
  - state = IDLE;
  - gnt0 = gnt1 = 0;
  - dvalid = 0;
  - dout = 0;
  - did = 0;
  - cnt = 0;
  - op = 0;
  - last-served pointer = 1, so req0 wins the first tie.
REQ-029 Reset asserted while in CONV SHALL abandon the conversion. No dvalid pulse SHALL follow, and cnt SHALL be unchanged from its reset value.
REQ-030 While rst_n is low, requests SHALL be ignored. The first grant can occur at the first edge with rst_n high.

Verification
REQ-031 Scenario: single requester.
  - Stimulus: req0=1, din0=4'd10 for one cycle after reset.
  - Response: gnt0 pulse; next cycle dvalid=1, dout=4'd15, did=0, cnt=1.
REQ-032 Scenario: simultaneous requests.
  - Stimulus: req0=req1=1 held, din0=4'd13, din1=4'd14.
  - Response: results alternate 11 (did=0), 9 (did=1), 11, 9; each dvalid is 2 cycles apart.
REQ-033 Scenario: sweep.
  - Stimulus: requester 1 issues din1 = 0..15.
  - Response: dout matches the REQ-016 table for every value; cnt=16.
REQ-034 Scenario: request during CONV.
  - Stimulus: req1 rises during CONV.
  - Response: no gnt1 in that cycle; gnt1 in the cycle after the following IDLE edge.
REQ-035 Scenario: reset mid-operation.
  - Stimulus: rst_n=0 in the CONV cycle.
  - Response: no dvalid; dout=0, cnt=0; next tie is granted to req0.
REQ-036 Scenario: saturation.
  - Stimulus: 260 back-to-back conversions.
  - Response: cnt stops at 255; dvalid still pulses each time.
